// File: rtl/mux_n_1_rr_reg.sv
// Registered N:1 stream selector with valid/ready on every channel.
// The source channel is either picked explicitly (fixed mode) or by a wrap-around round-robin arbiter.
module mux_n_1_rr_reg #(
   parameter  int WIDTH = 8,
   parameter  int CH    = 4,
   localparam int SEL_W = $clog2(CH)
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic [CH*WIDTH-1:0]   d_in,
   input  logic [CH-1:0]         valid_in,
   output logic [CH-1:0]         ready_out,
   input  logic                  mode_in,
   input  logic [SEL_W-1:0]      sel_in,
   output logic [WIDTH-1:0]      y_out,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic [SEL_W-1:0]      ch_out
);

   logic [WIDTH-1:0] ch_data [CH];
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [SEL_W-1:0] ch_q, ch_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] grant;
   logic [SEL_W-1:0] rr_grant;
   logic             load_en;
   logic             req;
   logic             xfer;

   for (genvar i = 0; i < CH; i++) begin : g_unpack
      assign ch_data[i] = d_in[i*WIDTH +: WIDTH];
   end

   // Scanning from the top down lets the channel closest to ptr overwrite the others.
   function automatic logic [SEL_W-1:0] rr_pick(input logic [CH-1:0] v, input logic [SEL_W-1:0] p);
      logic [SEL_W-1:0] pick;
      logic [SEL_W-1:0] idx;
      pick = p;
      for (int k = CH - 1; k >= 0; k--) begin
         idx = p + SEL_W'(k);
         if (v[idx]) pick = idx;
      end
      return pick;
   endfunction

   assign rr_grant = rr_pick(valid_in, ptr_q);

   always_comb begin
      load_en   = !valid_q || ready_in;
      grant     = sel_in;
      req       = valid_in[sel_in];
      ready_out = '0;
      valid_d   = valid_q;
      y_d       = y_q;
      ch_d      = ch_q;
      ptr_d     = ptr_q;

      if (mode_in) begin
         grant = rr_grant;
         req   = |valid_in;
      end

      // Fixed mode offers ready to the selected channel even when it is idle.
      if (rst_n_in && load_en && (req || !mode_in)) ready_out[grant] = 1'b1;

      xfer = rst_n_in && load_en && req;

      if (xfer) begin
         valid_d = 1'b1;
         y_d     = ch_data[grant];
         ch_d    = grant;
         if (mode_in) ptr_d = grant + SEL_W'(1);
      end else if (valid_q && ready_in) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         valid_q <= 1'b0;
         y_q     <= '0;
         ch_q    <= '0;
         ptr_q   <= '0;
      end else begin
         valid_q <= valid_d;
         y_q     <= y_d;
         ch_q    <= ch_d;
         ptr_q   <= ptr_d;
      end
   end

   assign valid_out = valid_q;
   assign y_out     = y_q;
   assign ch_out    = ch_q;

endmodule

// File: tb/tb_mux_n_1_rr_reg.sv
// Self-checking bench for mux_n_1_rr_reg (CH=4, WIDTH=8): vector table, scoreboard queue
// and hand-written sequences for reset, round-robin wrap, backpressure and mode switching.
module tb_mux_n_1_rr_reg;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic [31:0] d_in;
   logic [3:0]  valid_in;
   logic [3:0]  ready_out;
   logic        mode_in;
   logic [1:0]  sel_in;
   logic [7:0]  y_out;
   logic        valid_out;
   logic        ready_in;
   logic [1:0]  ch_out;

   logic [7:0]  d_ch [4];

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] y;
      logic [1:0] ch;
   } exp_t;
   exp_t sb_q [$];

   typedef struct {
      bit         mode;
      logic [1:0] sel;
      logic [3:0] valid;
      bit         rdy;
      logic [3:0] exp_ready;
      bit         exp_vout;
      logic [1:0] exp_ch;
   } vec_t;
   vec_t vecs [12];

   // Reference state: output register occupancy, last word, and round-robin pointer.
   logic       m_valid;
   logic [7:0] m_y;
   logic [1:0] m_ch;
   logic [1:0] m_ptr;
   bit         p_xfer;
   bit         p_mode;
   bit         p_ready;
   logic [1:0] p_g;

   int rr_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

   assign d_in = {d_ch[3], d_ch[2], d_ch[1], d_ch[0]};

   always #5 clk_in = ~clk_in;

   mux_n_1_rr_reg #(.WIDTH(8), .CH(4)) dut (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .d_in      (d_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .mode_in   (mode_in),
      .sel_in    (sel_in),
      .y_out     (y_out),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .ch_out    (ch_out)
   );

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Drives one cycle of inputs, checks combinational ready_out and queues any expected transfer.
   task automatic applyStimulus(input bit mode, input logic [1:0] sel, input logic [3:0] valid, input bit rdy);
      bit         load;
      bit         req;
      logic [1:0] g;
      logic [1:0] idx;
      logic [3:0] exp_ro;
      mode_in  = mode;
      sel_in   = sel;
      valid_in = valid;
      ready_in = rdy;
      #1;
      load = !m_valid || rdy;
      if (!mode) begin
         g   = sel;
         req = valid[sel];
      end else begin
         g = m_ptr;
         for (int k = 3; k >= 0; k--) begin
            idx = m_ptr + 2'(k);
            if (valid[idx]) g = idx;
         end
         req = |valid;
      end
      exp_ro = '0;
      if (load && (req || !mode)) exp_ro[g] = 1'b1;
      checkOutput("ready_out", {28'd0, ready_out}, {28'd0, exp_ro});
      p_xfer  = load && req;
      p_g     = g;
      p_mode  = mode;
      p_ready = rdy;
      if (p_xfer) sb_q.push_back({d_ch[g], g});
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk_in);
      #1;
      if (p_xfer) begin
         m_valid = 1'b1;
         if (p_mode) m_ptr = p_g + 2'd1;
      end else if (m_valid && p_ready) begin
         m_valid = 1'b0;
      end
      checkOutput("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
      if (p_xfer) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue expected a word at %0t", $time);
         end else begin
            e    = sb_q.pop_front();
            m_y  = e.y;
            m_ch = e.ch;
            checkOutput("sb_y_out", {24'd0, y_out}, {24'd0, e.y});
            checkOutput("sb_ch_out", {30'd0, ch_out}, {30'd0, e.ch});
         end
      end else begin
         checkOutput("hold_y_out", {24'd0, y_out}, {24'd0, m_y});
         checkOutput("hold_ch_out", {30'd0, ch_out}, {30'd0, m_ch});
      end
      p_xfer = 1'b0;
   endtask

   // Reset with every channel requesting, so a leaking ready_out would be visible.
   task automatic doReset(input int n);
      rst_n_in = 1'b0;
      mode_in  = 1'b1;
      sel_in   = 2'd0;
      valid_in = 4'b1111;
      ready_in = 1'b1;
      for (int i = 0; i < n; i++) begin
         #1;
         checkOutput("rst_ready_out", {28'd0, ready_out}, 32'd0);
         @(posedge clk_in);
         #1;
         checkOutput("rst_valid_out", {31'd0, valid_out}, 32'd0);
         checkOutput("rst_y_out", {24'd0, y_out}, 32'd0);
         checkOutput("rst_ch_out", {30'd0, ch_out}, 32'd0);
      end
      m_valid  = 1'b0;
      m_y      = 8'h00;
      m_ch     = 2'd0;
      m_ptr    = 2'd0;
      p_xfer   = 1'b0;
      sb_q.delete();
      rst_n_in = 1'b1;
      valid_in = 4'b0000;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      d_ch[0] = 8'h10;
      d_ch[1] = 8'h21;
      d_ch[2] = 8'h32;
      d_ch[3] = 8'h43;

      //            mode sel   valid    rdy  exp_ready vout ch
      vecs[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
      vecs[1]  = '{1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
      vecs[2]  = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b1000, 1'b0, 2'd1};
      vecs[3]  = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0};
      vecs[4]  = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0};
      vecs[5]  = '{1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
      vecs[6]  = '{1'b1, 2'd0, 4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2};
      vecs[7]  = '{1'b1, 2'd0, 4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1};
      vecs[8]  = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};
      vecs[9]  = '{1'b1, 2'd0, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3};
      vecs[10] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
      vecs[11] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};

      doReset(2);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].rdy);
         checkOutput("vec_ready_out", {28'd0, ready_out}, {28'd0, vecs[i].exp_ready});
         tick();
         checkOutput("vec_valid_out", {31'd0, valid_out}, {31'd0, vecs[i].exp_vout});
         checkOutput("vec_ch_out", {30'd0, ch_out}, {30'd0, vecs[i].exp_ch});
      end

      // Fixed select of channel 2.
      doReset(2);
      d_ch[2] = 8'hA5;
      applyStimulus(1'b0, 2'd2, 4'b1111, 1'b1);
      checkOutput("fixed_ready_out", {28'd0, ready_out}, 32'h4);
      tick();
      checkOutput("fixed_y_out", {24'd0, y_out}, 32'hA5);
      checkOutput("fixed_ch_out", {30'd0, ch_out}, 32'd2);
      checkOutput("fixed_valid_out", {31'd0, valid_out}, 32'd1);

      // Round-robin with every channel valid: full rotation starting at channel 0.
      doReset(2);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
         if (i == 0) checkOutput("first_grant", {28'd0, ready_out}, 32'h1);
         tick();
         checkOutput("rr_ch_out", {30'd0, ch_out}, rr_seq[i]);
         checkOutput("rr_valid_out", {31'd0, valid_out}, 32'd1);
      end

      // Sparse round-robin: move ptr to 1, then channels 0 and 3 alternate across the wrap.
      doReset(2);
      applyStimulus(1'b1, 2'd0, 4'b0001, 1'b1);
      tick();
      checkOutput("sparse_ch0", {30'd0, ch_out}, 32'd0);
      applyStimulus(1'b1, 2'd0, 4'b1001, 1'b1);
      tick();
      checkOutput("sparse_ch1", {30'd0, ch_out}, 32'd3);
      applyStimulus(1'b1, 2'd0, 4'b1001, 1'b1);
      tick();
      checkOutput("sparse_ch2", {30'd0, ch_out}, 32'd0);
      applyStimulus(1'b1, 2'd0, 4'b1001, 1'b1);
      tick();
      checkOutput("sparse_ch3", {30'd0, ch_out}, 32'd3);

      // Backpressure: hold 3C for three stalled cycles, then take it and load 5A with no bubble.
      doReset(2);
      d_ch[1] = 8'h3C;
      applyStimulus(1'b0, 2'd1, 4'b0010, 1'b1);
      tick();
      checkOutput("bp_load_y", {24'd0, y_out}, 32'h3C);
      d_ch[1] = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 2'd1, 4'b0010, 1'b0);
         checkOutput("bp_ready_out", {28'd0, ready_out}, 32'd0);
         tick();
         checkOutput("bp_y_out", {24'd0, y_out}, 32'h3C);
         checkOutput("bp_ch_out", {30'd0, ch_out}, 32'd1);
         checkOutput("bp_valid_out", {31'd0, valid_out}, 32'd1);
      end
      applyStimulus(1'b0, 2'd1, 4'b0010, 1'b1);
      checkOutput("bp_release_ready", {28'd0, ready_out}, 32'h2);
      tick();
      checkOutput("bp_next_y", {24'd0, y_out}, 32'h5A);
      checkOutput("bp_next_valid", {31'd0, valid_out}, 32'd1);

      // Reset while 5A is still held; then an idle selected channel and a switch to round-robin.
      doReset(1);
      d_ch[3] = 8'h77;
      applyStimulus(1'b0, 2'd3, 4'b1000, 1'b0);
      tick();
      checkOutput("ms_y_out", {24'd0, y_out}, 32'h77);
      applyStimulus(1'b0, 2'd3, 4'b0110, 1'b1);
      tick();
      checkOutput("ms_drain_valid", {31'd0, valid_out}, 32'd0);
      applyStimulus(1'b0, 2'd3, 4'b0110, 1'b1);
      tick();
      checkOutput("ms_idle_valid", {31'd0, valid_out}, 32'd0);
      applyStimulus(1'b1, 2'd3, 4'b0110, 1'b1);
      checkOutput("ms_rr_ready", {28'd0, ready_out}, 32'h2);
      tick();
      checkOutput("ms_rr_ch1", {30'd0, ch_out}, 32'd1);
      checkOutput("ms_rr_valid", {31'd0, valid_out}, 32'd1);
      applyStimulus(1'b1, 2'd3, 4'b0110, 1'b1);
      tick();
      checkOutput("ms_rr_ch2", {30'd0, ch_out}, 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
